pulse_output_driver: RTL and testbench
======================================

Name: pulse_output_driver

Overview:
- Transmit-side counterpart of the input synchronizer/debounce block.
- Consumes a pipeline_types::control_path_t edge stream (rising/falling event pulses) and regenerates a clean, registered, glitch-free level on an output pin.
- Enforces a minimum high dwell and a minimum low dwell, so downstream hardware sees no runt pulses; at most one edge is deferred during a dwell.
- Sits at the pin boundary, driving LED/indicator outputs from the control pipeline.

Parameters:
MIN_HIGH_CYCLES, 5, minimum cycles o_signal stays high once asserted (>=1)
MIN_LOW_CYCLES, 5, minimum cycles o_signal stays low once deasserted (>=1)

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous, active-high reset
i_control  input  pipeline_types::control_path_t  edge requests; .rising/.falling single-cycle pulses
o_signal  output  1  registered output level to pin
o_busy  output  1  high while a minimum dwell is in progress
o_overrun  output  1  one-cycle pulse when a request is dropped or cancelled

Behaviour:
- Interface: one clock i_clk; reset i_reset is asynchronous, active-high. All outputs registered.
- Reset values: o_signal=0, o_busy=0, o_overrun=0, state=LOW_IDLE, counter=0, pending=0.
- States: LOW_IDLE, HIGH_HOLD, HIGH_IDLE, LOW_HOLD. The o_signal level is 1 in the HIGH_* states and 0 in the LOW_* states. o_busy=1 in the *_HOLD states.
- Request decode each cycle:
  - rising&falling together: request ignored, o_overrun pulses next cycle.
  - Otherwise the asserted field is the request.
- Response to a request by state:
  - LOW_IDLE + rising: next cycle enter HIGH_HOLD, o_signal=1, counter=MIN_HIGH_CYCLES-1.
  - HIGH_IDLE + falling: next cycle enter LOW_HOLD, o_signal=0, counter=MIN_LOW_CYCLES-1.
  - Request matching the current level (rising while high, falling while low) with no pending edge: ignored silently, no overrun.
- In *_HOLD, the counter decrements each cycle while nonzero.
- Opposite-level request during HOLD:
  - If nothing is pending, set pending.
  - If an edge is already pending and a request back to the current level arrives, clear pending and pulse o_overrun (a runt pulse is swallowed).
- Dwell expiry (HOLD and counter==0), evaluated including a request arriving in that same cycle:
  - If pending (or a new opposite request), next cycle flip o_signal, enter the opposite HOLD and load its count, clear pending.
  - Else enter the matching *_IDLE.
- Latency: a request sampled at cycle N changes o_signal at N+1 when idle. Each level persists for at least MIN_*_CYCLES cycles: high occupies N+1..N+MIN_HIGH_CYCLES, and the earliest deferred fall appears at N+MIN_HIGH_CYCLES+1.
- MIN_*_CYCLES=1: the HOLD lasts exactly one cycle.
- Counter width is $clog2(max(MIN_HIGH_CYCLES,MIN_LOW_CYCLES)+1).
- Reset mid-dwell: immediately returns to reset values; pending is discarded.

Test Plan:
- Reset, then rising at cycle 10 -> o_signal=1 from cycle 11; o_busy=1 cycles 11-15; HIGH_IDLE at 16; o_signal stays 1.
- Rising at 10, falling at 12 -> o_signal high for cycles 11-15, low from 16, o_busy=1 cycles 11-20, no overrun.
- Rising at 10, falling at 12, rising at 13 -> o_overrun pulse at 14; o_signal remains 1 indefinitely; HIGH_IDLE from 16.
- Rising and falling both asserted at cycle 10 from LOW_IDLE -> o_signal stays 0; o_overrun=1 at cycle 11 only.
- Falling asserted exactly on the dwell-expiry cycle (rising at 10, falling at 15) -> o_signal low at 16, no gap through HIGH_IDLE.
- i_reset asserted asynchronously mid-HIGH_HOLD with an edge pending -> o_signal=0 and o_busy=0 immediately; after release, LOW_IDLE, and the pending edge is never emitted.

Source files
------------

// File: rtl/pulse_output_driver_if.sv
// Edge-request stream type and the pin-side bundle of the pulse output driver.
// Signal names are from the driver's point of view.
package pipeline_types;
  typedef struct packed {
    logic rising;
    logic falling;
  } control_path_t;
endpackage

interface pulse_output_driver_if;
  pipeline_types::control_path_t i_control;
  logic                          o_signal;
  logic                          o_busy;
  logic                          o_overrun;

  modport master (
    output i_control,
    input  o_signal,
    input  o_busy,
    input  o_overrun
  );

  modport slave (
    input  i_control,
    output o_signal,
    output o_busy,
    output o_overrun
  );
endinterface

// File: rtl/pulse_output_driver.sv
// Regenerates a glitch-free output level from rising/falling edge pulses.
// Enforces a minimum high and low dwell, deferring at most one edge.
module pulse_output_driver #(
  parameter int unsigned MIN_HIGH_CYCLES = 5,
  parameter int unsigned MIN_LOW_CYCLES  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  pulse_output_driver_if.slave  bus
);

  localparam int unsigned MaxCycles = (MIN_HIGH_CYCLES > MIN_LOW_CYCLES) ?
                                      MIN_HIGH_CYCLES : MIN_LOW_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] HighLoad = CntW'(MIN_HIGH_CYCLES - 1);
  localparam logic [CntW-1:0] LowLoad  = CntW'(MIN_LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    StLowIdle,
    StHighHold,
    StHighIdle,
    StLowHold
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            signal_q, signal_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic both, rise, fall, level, req_opp, req_same;

  assign both  = bus.i_control.rising & bus.i_control.falling;
  assign rise  = bus.i_control.rising & ~bus.i_control.falling;
  assign fall  = bus.i_control.falling & ~bus.i_control.rising;
  assign level = (state_q == StHighHold) || (state_q == StHighIdle);

  // Requests relative to the current level: opposite moves the pin, same is a no-op
  // unless it cancels a deferred edge.
  assign req_opp  = level ? fall : rise;
  assign req_same = level ? rise : fall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = both;

    unique case (state_q)
      StLowIdle: begin
        if (rise) begin
          state_d = StHighHold;
          cnt_d   = HighLoad;
        end
      end
      StHighIdle: begin
        if (fall) begin
          state_d = StLowHold;
          cnt_d   = LowLoad;
        end
      end
      StHighHold, StLowHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (req_opp && !pending_q) begin
            pending_d = 1'b1;
          end else if (req_same && pending_q) begin
            pending_d = 1'b0;
            overrun_d = 1'b1;
          end
        end else if (pending_q && req_same) begin
          // Cancel arriving on the expiry cycle swallows the deferred edge.
          pending_d = 1'b0;
          overrun_d = 1'b1;
          state_d   = level ? StHighIdle : StLowIdle;
        end else if (pending_q || req_opp) begin
          pending_d = 1'b0;
          state_d   = level ? StLowHold : StHighHold;
          cnt_d     = level ? LowLoad : HighLoad;
        end else begin
          state_d = level ? StHighIdle : StLowIdle;
        end
      end
      default: begin
        state_d = StLowIdle;
      end
    endcase

    signal_d = (state_d == StHighHold) || (state_d == StHighIdle);
    busy_d   = (state_d == StHighHold) || (state_d == StLowHold);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StLowIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      signal_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      signal_q  <= signal_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_signal  = signal_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_pulse_output_driver.sv
// Bench for pulse_output_driver: cycle vectors with expected outputs one cycle later,
// plus hand sequences for async reset mid-dwell and single-cycle dwell.
module tb_pulse_output_driver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_output_driver_if bus ();
  pulse_output_driver_if bus1 ();

  pulse_output_driver #(
    .MIN_HIGH_CYCLES(5),
    .MIN_LOW_CYCLES (5)
  ) u_dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  pulse_output_driver #(
    .MIN_HIGH_CYCLES(1),
    .MIN_LOW_CYCLES (1)
  ) u_dut1 (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus1)
  );

  typedef struct {
    logic rise;
    logic fall;
    logic sig;
    logic busy;
    logic ovr;
  } vec_t;

  typedef struct {
    logic sig;
    logic busy;
    logic ovr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic v(input logic r, input logic f, input logic s, input logic b, input logic o);
    vec_t x;
    x.rise = r;
    x.fall = f;
    x.sig  = s;
    x.busy = b;
    x.ovr  = o;
    vecs.push_back(x);
  endtask

  // From HIGH_IDLE back to LOW_IDLE through a full low dwell.
  task automatic ret_low();
    v(0, 1, 0, 1, 0);
    repeat (4) v(0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0);
  endtask

  task automatic step_vec(input vec_t x, input int idx);
    exp_t e;
    bus.i_control = '{rising: x.rise, falling: x.fall};
    e.sig  = x.sig;
    e.busy = x.busy;
    e.ovr  = x.ovr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.i_control = '0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty vec %0d got empty expected entry", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d signal", idx), bus.o_signal, e.sig);
      chk($sformatf("v%0d busy", idx), bus.o_busy, e.busy);
      chk($sformatf("v%0d overrun", idx), bus.o_overrun, e.ovr);
    end
  endtask

  task automatic step1(input logic r, input logic f, input logic s, input logic b,
                       input logic o, input string name);
    bus1.i_control = '{rising: r, falling: f};
    @(posedge clk);
    #1;
    bus1.i_control = '0;
    chk({name, " signal"}, bus1.o_signal, s);
    chk({name, " busy"}, bus1.o_busy, b);
    chk({name, " overrun"}, bus1.o_overrun, o);
  endtask

  initial begin
    vec_t idle_v;

    // Rise only: 5-cycle high dwell then HIGH_IDLE.
    v(1, 0, 1, 1, 0);
    repeat (4) v(0, 0, 1, 1, 0);
    v(0, 0, 1, 0, 0);
    v(0, 0, 1, 0, 0);
    ret_low();
    // Rise then fall two cycles later: fall deferred to dwell end.
    v(1, 0, 1, 1, 0);
    v(0, 0, 1, 1, 0);
    v(0, 1, 1, 1, 0);
    v(0, 0, 1, 1, 0);
    v(0, 0, 1, 1, 0);
    v(0, 0, 0, 1, 0);
    repeat (4) v(0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0);
    // Rise, fall, rise: deferred fall cancelled with overrun.
    v(1, 0, 1, 1, 0);
    v(0, 0, 1, 1, 0);
    v(0, 1, 1, 1, 0);
    v(1, 0, 1, 1, 1);
    v(0, 0, 1, 1, 0);
    v(0, 0, 1, 0, 0);
    v(0, 0, 1, 0, 0);
    ret_low();
    // Both edges at once from LOW_IDLE.
    v(1, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0);
    // Fall on the expiry cycle flips straight into LOW_HOLD.
    v(1, 0, 1, 1, 0);
    repeat (4) v(0, 0, 1, 1, 0);
    v(0, 1, 0, 1, 0);
    repeat (4) v(0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0);
    // Same-level requests are silent; both-at-once during hold only pulses overrun.
    v(1, 0, 1, 1, 0);
    v(1, 0, 1, 1, 0);
    v(1, 1, 1, 1, 1);
    v(0, 0, 1, 1, 0);
    v(0, 0, 1, 1, 0);
    v(0, 0, 1, 0, 0);
    v(1, 0, 1, 0, 0);
    ret_low();

    rst            = 1'b1;
    bus.i_control  = '0;
    bus1.i_control = '0;
    #1;
    chk("reset signal", bus.o_signal, 1'b0);
    chk("reset busy", bus.o_busy, 1'b0);
    chk("reset overrun", bus.o_overrun, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle signal", bus.o_signal, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step_vec(vecs[i], i);
    end

    // Single-cycle dwell instance.
    step1(1, 0, 1, 1, 0, "m1 rise");
    step1(0, 0, 1, 0, 0, "m1 high idle");
    step1(0, 1, 0, 1, 0, "m1 fall");
    step1(1, 0, 1, 1, 0, "m1 rise on expiry");
    step1(0, 0, 1, 0, 0, "m1 high idle2");
    step1(0, 1, 0, 1, 0, "m1 fall2");
    step1(0, 0, 0, 0, 0, "m1 low idle");

    // Async reset mid HIGH_HOLD with a pending fall.
    bus.i_control = '{rising: 1'b1, falling: 1'b0};
    @(posedge clk);
    #1;
    bus.i_control = '{rising: 1'b0, falling: 1'b1};
    @(posedge clk);
    #1;
    bus.i_control = '0;
    chk("pre-reset signal", bus.o_signal, 1'b1);
    chk("pre-reset busy", bus.o_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset signal", bus.o_signal, 1'b0);
    chk("async reset busy", bus.o_busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_v = '{rise: 1'b0, fall: 1'b0, sig: 1'b0, busy: 1'b0, ovr: 1'b0};
    for (int i = 0; i < 10; i++) begin
      step_vec(idle_v, 1000 + i);
    end
    // Still in LOW_IDLE: a rise responds immediately.
    idle_v.rise = 1'b1;
    idle_v.sig  = 1'b1;
    idle_v.busy = 1'b1;
    step_vec(idle_v, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
